// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, RGB565 colours and total-count helpers for the LCD timing generator.
// Consumed by lcd_timing_gen (optional colour bars under LCD_COLORBAR_EN) and lcd_hv_counter.
package lcd_timing_pkg;

  function automatic int unsigned line_total(input int unsigned sync, input int unsigned back,
                                             input int unsigned disp, input int unsigned front);
    return sync + back + disp + front;
  endfunction

  // 800x480 TFT at 33.3 MHz
  localparam int unsigned LCD800_H_SYNC  = 128;
  localparam int unsigned LCD800_H_BACK  = 88;
  localparam int unsigned LCD800_H_DISP  = 800;
  localparam int unsigned LCD800_H_FRONT = 40;
  localparam int unsigned LCD800_V_SYNC  = 2;
  localparam int unsigned LCD800_V_BACK  = 33;
  localparam int unsigned LCD800_V_DISP  = 480;
  localparam int unsigned LCD800_V_FRONT = 10;
  localparam int unsigned LCD800_H_TOTAL =
    line_total(LCD800_H_SYNC, LCD800_H_BACK, LCD800_H_DISP, LCD800_H_FRONT);
  localparam int unsigned LCD800_V_TOTAL =
    line_total(LCD800_V_SYNC, LCD800_V_BACK, LCD800_V_DISP, LCD800_V_FRONT);

  // 480x272 TFT at 9 MHz
  localparam int unsigned LCD480_H_SYNC  = 41;
  localparam int unsigned LCD480_H_BACK  = 2;
  localparam int unsigned LCD480_H_DISP  = 480;
  localparam int unsigned LCD480_H_FRONT = 2;
  localparam int unsigned LCD480_V_SYNC  = 10;
  localparam int unsigned LCD480_V_BACK  = 2;
  localparam int unsigned LCD480_V_DISP  = 272;
  localparam int unsigned LCD480_V_FRONT = 2;
  localparam int unsigned LCD480_H_TOTAL =
    line_total(LCD480_H_SYNC, LCD480_H_BACK, LCD480_H_DISP, LCD480_H_FRONT);
  localparam int unsigned LCD480_V_TOTAL =
    line_total(LCD480_V_SYNC, LCD480_V_BACK, LCD480_V_DISP, LCD480_V_FRONT);

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_hv_counter.sv
// Free-running horizontal/vertical position counter; h wraps at H_TOTAL, v steps on each h wrap
// and wraps at V_TOTAL.
module lcd_hv_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL = LCD800_H_TOTAL,
  parameter int unsigned V_TOTAL = LCD800_V_TOTAL,
  localparam int unsigned HW = $clog2(H_TOTAL),
  localparam int unsigned VW = $clog2(V_TOTAL)
)
(
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB panel timing generator: centres the camera image in the active area and requests one FIFO
// pixel per image position. Optional colour-bar test pattern under macro LCD_COLORBAR_EN.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC  = LCD800_H_SYNC,
  parameter int unsigned H_BACK  = LCD800_H_BACK,
  parameter int unsigned H_DISP  = LCD800_H_DISP,
  parameter int unsigned H_FRONT = LCD800_H_FRONT,
  parameter int unsigned V_SYNC  = LCD800_V_SYNC,
  parameter int unsigned V_BACK  = LCD800_V_BACK,
  parameter int unsigned V_DISP  = LCD800_V_DISP,
  parameter int unsigned V_FRONT = LCD800_V_FRONT,
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmos_data,
`ifdef LCD_COLORBAR_EN
  input  logic        colorbar_en,
`endif
  output logic        data_req,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = line_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int unsigned V_TOTAL = line_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned H_ACT   = H_SYNC + H_BACK;
  localparam int unsigned V_ACT   = V_SYNC + V_BACK;
  localparam int unsigned X0      = (H_DISP - IMG_W) / 2;
  localparam int unsigned Y0      = (V_DISP - IMG_H) / 2;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [31:0]   hx, vx;
  logic          hs_n, vs_n, de, img, img_q;

  lcd_hv_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_hv_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt)
  );

  // Compare in 32 bits so window bounds equal to the total never overflow the counter width.
  assign hx   = 32'(h_cnt);
  assign vx   = 32'(v_cnt);
  assign hs_n = (hx >= H_SYNC);
  assign vs_n = (vx >= V_SYNC);
  assign de   = (hx >= H_ACT) && (hx < H_ACT + H_DISP) &&
                (vx >= V_ACT) && (vx < V_ACT + V_DISP);
  assign img  = (hx >= H_ACT + X0) && (hx < H_ACT + X0 + IMG_W) &&
                (vx >= V_ACT + Y0) && (vx < V_ACT + Y0 + IMG_H);

  assign data_req = img & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_hs      <= 1'b1;
      lcd_vs      <= 1'b1;
      lcd_de      <= 1'b0;
      img_q       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      lcd_hs      <= hs_n;
      lcd_vs      <= vs_n;
      lcd_de      <= de;
      img_q       <= img;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef LCD_COLORBAR_EN
  localparam int unsigned BAR_W = H_DISP / 8;

  logic [31:0] bar_idx;
  logic [2:0]  bar, bar_q;

  // Positions outside the active area wrap to large indices and clamp to the last bar;
  // they are masked by lcd_de anyway.
  always_comb begin
    bar_idx = (hx - H_ACT) / BAR_W;
    bar     = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bar_q <= 3'd0;
    else        bar_q <= bar;
  end

  always_comb begin
    lcd_rgb = img_q ? cmos_data : RGB_BLACK;
    if (colorbar_en) lcd_rgb = lcd_de ? bar_color(bar_q) : RGB_BLACK;
  end
`else
  assign lcd_rgb = img_q ? cmos_data : RGB_BLACK;
`endif

endmodule
